// File: rtl/line_scan_ctrl.sv
// line_scan_ctrl: move-advisor sequencer for the tic-tac-toe board.
// One three-cell line checker is time-shared across the 8 board lines. The
// win phase looks for a line the mover can complete. The block phase looks
// for a line the opponent could complete. The first hit is reported.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     synchronous active-low reset
//   start     scan request, accepted only when idle
//   board     9 cells x 2 bits, cell i = board[2i+1:2i], row-major
//   turn      mover: 0 = P1, 1 = P2
//   busy      high while scanning
//   done      one-cycle pulse, results valid
//   found     a win/block line was found
//   is_win    1 = win move, 0 = block move
//   line_idx  line of the hit (0 when not found)
//   cell_idx  blank cell to play (0 when not found)
module line_scan_ctrl #(
   parameter bit CHECK_BLOCK = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [17:0] board,
   input  logic        turn,
   output logic        busy,
   output logic        done,
   output logic        found,
   output logic        is_win,
   output logic [2:0]  line_idx,
   output logic [3:0]  cell_idx
);

   typedef enum logic [1:0] {IDLE, SCAN_WIN, SCAN_BLOCK, DONE} state_t;

   state_t      state;
   logic [17:0] brd_q;
   logic        turn_q;
   logic [2:0]  idx;

   // cell numbers {a,b,c} of each line
   function automatic logic [11:0] line_cells(input logic [2:0] l);
      case (l)
         3'd0:    line_cells = {4'd0, 4'd1, 4'd2};
         3'd1:    line_cells = {4'd3, 4'd4, 4'd5};
         3'd2:    line_cells = {4'd6, 4'd7, 4'd8};
         3'd3:    line_cells = {4'd0, 4'd3, 4'd6};
         3'd4:    line_cells = {4'd1, 4'd4, 4'd7};
         3'd5:    line_cells = {4'd2, 4'd5, 4'd8};
         3'd6:    line_cells = {4'd0, 4'd4, 4'd8};
         default: line_cells = {4'd2, 4'd4, 4'd6};
      endcase
   endfunction

   function automatic logic [1:0] cell_of(input logic [17:0] b, input logic [3:0] c);
      cell_of = b[{c, 1'b0} +: 2];
   endfunction

   logic [11:0] cells;
   logic [3:0]  ca, cb, cc;
   logic [1:0]  va, vb, vc;
   logic [1:0]  pcode;
   logic        hit;
   logic [3:0]  blank;

   // Shared line checker: exactly one blank and the other two equal to the
   // checked player's code. Invalid (11) cells never match either.
   always_comb begin
      cells = line_cells(idx);
      ca    = cells[11:8];
      cb    = cells[7:4];
      cc    = cells[3:0];
      va    = cell_of(brd_q, ca);
      vb    = cell_of(brd_q, cb);
      vc    = cell_of(brd_q, cc);
      // block phase checks the opponent
      pcode = ((state == SCAN_BLOCK) ? ~turn_q : turn_q) ? 2'b10 : 2'b01;
      hit   = 1'b0;
      blank = 4'd0;
      if (va == 2'b00 && vb == pcode && vc == pcode) begin
         hit = 1'b1; blank = ca;
      end else if (vb == 2'b00 && va == pcode && vc == pcode) begin
         hit = 1'b1; blank = cb;
      end else if (vc == 2'b00 && va == pcode && vb == pcode) begin
         hit = 1'b1; blank = cc;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         brd_q    <= '0;
         turn_q   <= 1'b0;
         idx      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         found    <= 1'b0;
         is_win   <= 1'b0;
         line_idx <= '0;
         cell_idx <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  brd_q    <= board;
                  turn_q   <= turn;
                  idx      <= '0;
                  busy     <= 1'b1;
                  found    <= 1'b0;
                  is_win   <= 1'b0;
                  line_idx <= '0;
                  cell_idx <= '0;
                  state    <= SCAN_WIN;
               end
            end
            SCAN_WIN: begin
               if (hit) begin
                  found    <= 1'b1;
                  is_win   <= 1'b1;
                  line_idx <= idx;
                  cell_idx <= blank;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  state    <= DONE;
               end else if (idx != 3'd7) begin
                  idx <= idx + 3'd1;
               end else if (CHECK_BLOCK) begin
                  idx   <= '0;
                  state <= SCAN_BLOCK;
               end else begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            SCAN_BLOCK: begin
               if (hit) begin
                  found    <= 1'b1;
                  is_win   <= 1'b0;
                  line_idx <= idx;
                  cell_idx <= blank;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  state    <= DONE;
               end else if (idx != 3'd7) begin
                  idx <= idx + 3'd1;
               end else begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            default: begin // DONE: single-cycle pulse, start ignored here
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
